// File: rtl/srff_ctrl_pkg.sv
// Shared types and constants for the SR flip-flop controller.
package srff_ctrl_pkg;

   // Controller FSM states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StGap   = 2'd2,
      StAck   = 2'd3
   } state_e;

   // Operation encoding carried on OP_A / OP_B.
   localparam logic OP_SET   = 1'b1;
   localparam logic OP_RESET = 1'b0;

   // Width of the shared pulse/gap down-counter.
   localparam int unsigned CNT_W = 4;

   // Requester index, also used as the round-robin priority pointer.
   typedef enum logic {
      ReqA = 1'b0,
      ReqB = 1'b1
   } req_idx_e;

   // The requester that did not win; the pointer moves there after a grant.
   function automatic req_idx_e other_side(req_idx_e idx);
      return (idx == ReqA) ? ReqB : ReqA;
   endfunction

endpackage

// File: rtl/srff_ctrl_cell.sv
// srff_cell: clocked SR flip-flop with asynchronous active-low clear.
// S has priority over R in the next-state logic; the controller never drives both.
module srff_cell (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic s_i,
   input  logic r_i,
   output logic q_o,
   output logic q_prim_o
);

   logic q_q;

   // Set, clear or hold on each rising edge; reset clears asynchronously.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_q <= 1'b0;
      end else if (s_i) begin
         q_q <= 1'b1;
      end else if (r_i) begin
         q_q <= 1'b0;
      end
   end

   assign q_o      = q_q;
   assign q_prim_o = ~q_q;

endmodule

// File: rtl/srff_ctrl.sv
// srff_ctrl: two-requester round-robin controller that pulses S/R into an SR cell.
// Optional build macro SRFF_READBACK_EN adds a sticky Q-versus-OP readback check on ERR.
module srff_ctrl
   import srff_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic req_a_i,
   input  logic op_a_i,
   output logic ack_a_o,
   input  logic req_b_i,
   input  logic op_b_i,
   output logic ack_b_o,
   output logic s_o,
   output logic r_o,
   output logic q_o,
   output logic q_prim_o,
   output logic busy_o,
   output logic err_o
);

   // Counter reload values: the counter holds "cycles remaining minus one".
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   req_idx_e           grant_q, grant_d;
   req_idx_e           ptr_q, ptr_d;

   req_idx_e           grant_sel;
   logic               op_sel;
   logic               q;

   // Round-robin pick: pointer side wins a tie, a lone request always wins.
   always_comb begin
      grant_sel = ptr_q;
      if (req_a_i && req_b_i) begin
         grant_sel = ptr_q;
      end else if (req_a_i) begin
         grant_sel = ReqA;
      end else if (req_b_i) begin
         grant_sel = ReqB;
      end
      op_sel = (grant_sel == ReqA) ? op_a_i : op_b_i;
   end

   // Next-state logic for the controller FSM and the shared down-counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (req_a_i || req_b_i) begin
               grant_d = grant_sel;
               op_d    = op_sel;
               ptr_d   = other_side(grant_sel);
               // Cell already holds the requested value: skip the pulse.
               if (op_sel == q) begin
                  state_d = StAck;
               end else begin
                  state_d = StDrive;
                  cnt_d   = PULSE_LOAD;
               end
            end
         end
         StDrive: begin
            if (cnt_q == '0) begin
               if (GAP_CYC == 0) begin
                  state_d = StAck;
               end else begin
                  state_d = StGap;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StAck;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= OP_RESET;
         grant_q <= ReqA;
         ptr_q   <= ReqA;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Drives decode straight from the state register, so reset forces S=R=0 at once.
   assign s_o     = (state_q == StDrive) && (op_q == OP_SET);
   assign r_o     = (state_q == StDrive) && (op_q == OP_RESET);
   assign ack_a_o = (state_q == StAck) && (grant_q == ReqA);
   assign ack_b_o = (state_q == StAck) && (grant_q == ReqB);
   assign busy_o  = (state_q != StIdle);

   srff_cell u_cell (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .s_i      (s_o),
      .r_i      (r_o),
      .q_o      (q),
      .q_prim_o (q_prim_o)
   );

   assign q_o = q;

`ifdef SRFF_READBACK_EN
   logic err_q;
   logic mismatch;

   // Q is settled by the time ACK is reached (S=R=0 there), so check it in that cycle.
   assign mismatch = (state_q == StAck) && (q != op_q);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | mismatch;
      end
   end

   assign err_o = err_q | mismatch;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_srff_ctrl.sv
// Directed, table-driven bench for srff_ctrl with default PULSE_CYC=2, GAP_CYC=1.
module tb_srff_ctrl;

   logic clk;
   logic rst_n;
   logic req_a, op_a, ack_a;
   logic req_b, op_b, ack_b;
   logic s, r, q, q_prim, busy, err;

   int n_cmp;
   int n_fail;

   srff_ctrl dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .req_a_i  (req_a),
      .op_a_i   (op_a),
      .ack_a_o  (ack_a),
      .req_b_i  (req_b),
      .op_b_i   (op_b),
      .ack_b_o  (ack_b),
      .s_o      (s),
      .r_o      (r),
      .q_o      (q),
      .q_prim_o (q_prim),
      .busy_o   (busy),
      .err_o    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied before an edge; expected outputs seen just after it.
   typedef struct packed {
      logic       ra;
      logic       oa;
      logic       rb;
      logic       ob;
      logic [7:0] exp;  // {s, r, q, q_prim, ack_a, ack_b, busy, err}
   } vec_t;

   localparam int NVEC = 32;
   vec_t vecs [NVEC];

   function automatic vec_t mk(bit ra, bit oa, bit rb, bit ob,
                               bit es, bit er, bit eq, bit eaa, bit eab, bit ebusy);
      vec_t v;
      v.ra  = ra;
      v.oa  = oa;
      v.rb  = rb;
      v.ob  = ob;
      v.exp = {es, er, eq, ~eq, eaa, eab, ebusy, 1'b0};
      return v;
   endfunction

   function automatic logic [7:0] outv();
      return {s, r, q, q_prim, ack_a, ack_b, busy, err};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                ra oa rb ob   s  r  q aa ab busy
      vecs[0]  = mk(1, 1, 1, 0,  1, 0, 0, 0, 0, 1);  // tie, ptr=A: A sets
      vecs[1]  = mk(1, 1, 1, 0,  1, 0, 1, 0, 0, 1);
      vecs[2]  = mk(1, 1, 1, 0,  0, 0, 1, 0, 0, 1);  // gap
      vecs[3]  = mk(1, 1, 1, 0,  0, 0, 1, 1, 0, 1);  // ack A
      vecs[4]  = mk(0, 0, 1, 0,  0, 0, 1, 0, 0, 0);
      vecs[5]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 1);  // B clears
      vecs[6]  = mk(0, 0, 1, 0,  0, 1, 0, 0, 0, 1);
      vecs[7]  = mk(0, 0, 1, 0,  0, 0, 0, 0, 0, 1);
      vecs[8]  = mk(0, 0, 1, 0,  0, 0, 0, 0, 1, 1);  // ack B
      vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 1, 0,  0, 0, 0, 0, 1, 1);  // fast path clear
      vecs[12] = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      vecs[13] = mk(1, 1, 0, 0,  1, 0, 0, 0, 0, 1);  // A sets
      vecs[14] = mk(1, 1, 0, 0,  1, 0, 1, 0, 0, 1);
      vecs[15] = mk(1, 1, 0, 0,  0, 0, 1, 0, 0, 1);
      vecs[16] = mk(1, 1, 0, 0,  0, 0, 1, 1, 0, 1);
      vecs[17] = mk(0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
      vecs[18] = mk(0, 0, 1, 1,  0, 0, 1, 0, 1, 1);  // fast path set, no S
      vecs[19] = mk(0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
      vecs[20] = mk(0, 0, 1, 1,  0, 0, 1, 0, 1, 1);  // held req is a new request
      vecs[21] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
      vecs[22] = mk(1, 0, 1, 1,  0, 1, 1, 0, 0, 1);  // tie, ptr=A: A clears
      vecs[23] = mk(1, 0, 1, 1,  0, 1, 0, 0, 0, 1);
      vecs[24] = mk(1, 0, 1, 1,  0, 0, 0, 0, 0, 1);
      vecs[25] = mk(1, 0, 1, 1,  0, 0, 0, 1, 0, 1);
      vecs[26] = mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
      vecs[27] = mk(0, 0, 1, 1,  1, 0, 0, 0, 0, 1);  // B sets
      vecs[28] = mk(0, 0, 1, 1,  1, 0, 1, 0, 0, 1);
      vecs[29] = mk(0, 0, 1, 1,  0, 0, 1, 0, 0, 1);
      vecs[30] = mk(0, 0, 1, 1,  0, 0, 1, 0, 1, 1);
      vecs[31] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0, 0);

      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      req_a  = 1'b0;
      op_a   = 1'b0;
      req_b  = 1'b0;
      op_b   = 1'b0;

      // Reset then idle.
      #2;
      chk("reset_state", outv(), 8'b0001_0000);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", outv(), 8'b0001_0000);
      tick();
      chk("idle_stays", outv(), 8'b0001_0000);

      // Main table.
      for (int i = 0; i < NVEC; i++) begin
         req_a = vecs[i].ra;
         op_a  = vecs[i].oa;
         req_b = vecs[i].rb;
         op_b  = vecs[i].ob;
         tick();
         chk($sformatf("vec%0d", i), outv(), vecs[i].exp);
         chk($sformatf("vec%0d_sr_excl", i), {7'b0, s & r}, 8'b0);
      end

      // Asynchronous reset clears Q=1 without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_clear", outv(), 8'b0001_0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Mid-op reset: A granted (pointer moves to B), then reset in first DRIVE cycle.
      req_a = 1'b1;
      op_a  = 1'b1;
      tick();
      chk("midop_drive", outv(), 8'b1001_0010);
      rst_n = 1'b0;
      #1;
      chk("midop_rst", outv(), 8'b0001_0000);
      req_b = 1'b1;
      op_b  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // Pointer back at A: the tie goes to A, so S (not R) pulses.
      tick();
      chk("ptr_reset_grant", outv(), 8'b1001_0010);
      tick();
      chk("midop_q_set", outv(), 8'b1010_0010);
      tick();
      chk("midop_gap", outv(), 8'b0010_0010);
      tick();
      chk("midop_ack", outv(), 8'b0010_1010);
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      chk("midop_idle", outv(), 8'b0010_0000);

      // Request dropped after grant still completes with an ACK.
      req_a = 1'b1;
      op_a  = 1'b0;
      tick();
      chk("drop_drive", outv(), 8'b0110_0010);
      req_a = 1'b0;
      tick();
      chk("drop_drive2", outv(), 8'b0101_0010);
      tick();
      chk("drop_gap", outv(), 8'b0001_0010);
      tick();
      chk("drop_ack", outv(), 8'b0001_1010);
      tick();
      chk("drop_idle", outv(), 8'b0001_0000);

`ifdef SRFF_READBACK_EN
      // Hold the cell low during a set: readback must flag it and keep it.
      req_a = 1'b1;
      op_a  = 1'b1;
      tick();
      force dut.u_cell.q_q = 1'b0;
      tick();
      tick();
      tick();
      chk("rb_err_at_ack", {ack_a, err, 6'b0}, 8'b1100_0000);
      release dut.u_cell.q_q;
      req_a = 1'b0;
      tick();
      chk("rb_err_sticky", {7'b0, err}, 8'b0000_0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rb_err_reset", {7'b0, err}, 8'b0);
      @(negedge clk);
      rst_n = 1'b1;
`else
      chk("err_tied_low", {7'b0, err}, 8'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/srff_ctrl.md
SRFF_CTRL -- requirements
Module: srff_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 2: cycles S or R is held asserted per operation (legal range 1..15).
REQ-002 Parameter GAP_CYC, default 1: cycles S=R=0 is held after a pulse before acknowledge (legal range 0..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_A  input  1  requester A operation request; held high until ACK_A.
REQ-006 OP_A  input  1  requester A operation: 1 = set, 0 = reset; stable while REQ_A high.
REQ-007 ACK_A  output  1  one-cycle acknowledge to requester A.
REQ-008 REQ_B, OP_B, ACK_B  same directions, widths and meanings as the A ports, for requester B.
REQ-009 S  output  1  set drive to the flip-flop cell.
REQ-010 R  output  1  reset drive to the flip-flop cell.
REQ-011 Q  output  1  flip-flop state; Q_PRIM  output  1  complement of Q.
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 ERR  output  1  sticky readback-mismatch flag.

Function
REQ-014 FSM states: IDLE, DRIVE, GAP, ACK.
REQ-015 IDLE: on an edge with any REQ high, grant one requester, latch its OP, and go to DRIVE; with no REQ high, stay in IDLE.
REQ-016 Arbitration is round-robin.
  - Priority pointer = A after reset.
  - When both REQs are high, the pointer side wins.
  - Pointer moves to the non-granted side after every grant.
  - A lone request wins regardless of the pointer.
REQ-017 Fast path: if the latched OP equals current Q, go IDLE -> ACK directly, with no S/R pulse.
REQ-018 DRIVE: for exactly PULSE_CYC cycles, S=1,R=0 (set) or S=0,R=1 (reset); then go to GAP, or to ACK if GAP_CYC=0.
REQ-019 GAP: S=R=0 for exactly GAP_CYC cycles, then go to ACK.
REQ-020 ACK: assert ACK of the granted requester for exactly one cycle, then go to IDLE.
REQ-021 Latency: a request sampled at edge k is acknowledged in cycle k+1+PULSE_CYC+GAP_CYC (defaults: 4 cycles), or in cycle k+1 on the fast path.
REQ-022 S and R are never both 1 in any cycle, including across reset.
REQ-023 Q updates on the edge following the first DRIVE cycle: S sets Q=1, R clears Q=0, S=R=0 holds Q.
REQ-024 Q_PRIM = ~Q at all times after reset.
REQ-025 A request dropped before its ACK is ignored; the in-flight sequence still completes and ACK still pulses.
REQ-026 ACK_A and ACK_B are never high in the same cycle.
REQ-027 A request still high in the cycle after its ACK is treated as a new request.

Reset
REQ-028 While RST_N is low, the block asynchronously forces:
  - state = IDLE;
  - S=R=0, Q=0, Q_PRIM=1;
  - ACK_A=ACK_B=0, BUSY=0, ERR=0;
  - pointer = A.
REQ-029 Reset asserted mid-DRIVE aborts the operation with no ACK; the requester re-arbitrates after reset releases.
REQ-030 The first rising edge after RST_N rises is treated as a normal IDLE cycle.

Configuration
REQ-031 Macro SRFF_READBACK_EN defined: on entry to ACK, compare Q against the latched OP; on mismatch set ERR=1 until reset.
REQ-032 Macro SRFF_READBACK_EN undefined: ERR is tied to 0 and no compare logic is built.

Structure
REQ-033 Package srff_ctrl_pkg holds:
  - the FSM state enum;
  - OP_SET/OP_RESET constants;
  - the requester-index type.
REQ-034 Sub-module srff_cell: clocked SR flip-flop with asynchronous active-low clear, ports S, R, CLK, RST_N, Q, Q_PRIM; instantiated once.
REQ-035 Pulse and gap timing share one 4-bit down-counter.

Verification
REQ-036 Reset then idle: RST_N=0 then 1, no requests -> Q=0, Q_PRIM=1, BUSY=0, ACK_A=ACK_B=0, ERR=0.
REQ-037 Set: REQ_A=1, OP_A=1 sampled at edge k (Q=0) ->
  - S=1 in cycles k+1 and k+2;
  - Q=1 from edge k+2;
  - ACK_A=1 in cycle k+4 only.
REQ-038 Contention: REQ_A=REQ_B=1 with OP_A=1, OP_B=0 after reset ->
  - A is acknowledged first, Q=1;
  - B is acknowledged next, Q=0;
  - S and R are never both 1.
REQ-039 Fast path: Q=1 and REQ_B=1, OP_B=1 -> no S pulse; ACK_B in the cycle after sampling.
REQ-040 Mid-op reset: RST_N low during the first DRIVE cycle of a set -> Q=0, S=0, no ACK; after release, the held REQ completes normally.
REQ-041 Readback with SRFF_READBACK_EN: force srff_cell Q low during a set -> ERR=1 at ACK and held until reset; without the macro, ERR stays 0.
